// File: rtl/updown_mod_counter.sv
// Synchronous modulo-N up/down counter with load, terminal count and wrap pulse.
// Define UPDOWN_MOD_COUNTER_SAT_EN to saturate at the limits instead of wrapping.
module updown_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic at_max;
    logic at_min;

    assign at_max = (q == MAX);
    assign at_min = (q == '0);
    assign qbar   = ~q;

    // tc flags the cycle before a wrap so a following stage can use it as its enable
    assign tc = en & ~load & ((up & at_max) | (~up & at_min));

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            q   <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            q   <= (d > MAX) ? MAX : d;
            ovf <= 1'b0;
        end else if (en) begin
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
            ovf <= 1'b0;
            if (up) begin
                q <= at_max ? MAX : q + WIDTH'(1);
            end else begin
                q <= at_min ? '0 : q - WIDTH'(1);
            end
`else
            if (up) begin
                q   <= at_max ? '0 : q + WIDTH'(1);
                ovf <= at_max;
            end else begin
                q   <= at_min ? MAX : q - WIDTH'(1);
                ovf <= at_min;
            end
`endif
        end else begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomised and directed bench for updown_mod_counter against an integer model.
module tb_updown_mod_counter;

    logic clk = 1'b0;
    logic r_n;
    always #5 clk = ~clk;

    // Main DUT: MODULUS=10
    logic       en_a, up_a, load_a, tc_a, ovf_a;
    logic [3:0] d_a, q_a, qbar_a;
    // Full-range DUT: MODULUS=16
    logic       en_b, up_b, load_b, tc_b, ovf_b;
    logic [3:0] d_b, q_b, qbar_b;
    // Cascaded decade pair
    logic       cen, cup, c1_tc, c1_ovf, c2_tc, c2_ovf;
    logic [3:0] c1_q, c1_qbar, c2_q, c2_qbar;
    logic [3:0] zero4 = 4'd0;
    logic       zero1 = 1'b0;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .r_n(r_n), .en(en_a), .up(up_a), .load(load_a), .d(d_a),
        .q(q_a), .qbar(qbar_a), .tc(tc_a), .ovf(ovf_a));
    updown_mod_counter #(.WIDTH(4), .MODULUS(16)) dut_b (
        .clk(clk), .r_n(r_n), .en(en_b), .up(up_b), .load(load_b), .d(d_b),
        .q(q_b), .qbar(qbar_b), .tc(tc_b), .ovf(ovf_b));
    updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_c1 (
        .clk(clk), .r_n(r_n), .en(cen), .up(cup), .load(zero1), .d(zero4),
        .q(c1_q), .qbar(c1_qbar), .tc(c1_tc), .ovf(c1_ovf));
    updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_c2 (
        .clk(clk), .r_n(r_n), .en(c1_tc), .up(cup), .load(zero1), .d(zero4),
        .q(c2_q), .qbar(c2_qbar), .tc(c2_tc), .ovf(c2_ovf));

    int checks = 0;
    int errors = 0;
    int mq_a = 0, mq_b = 0, mc = 0;
    bit movf_a = 0, movf_b = 0;
    bit exp_tc;

    function automatic bit model_tc(input int m, input int q, input bit en, input bit up, input bit load);
        return en && !load && (up ? (q == m - 1) : (q == 0));
    endfunction

    function automatic void model_step(input int m, input int q, input bit en, input bit up,
                                       input bit load, input int d, output int nq, output bit novf);
        nq   = q;
        novf = 1'b0;
        if (load) begin
            nq = (d > m - 1) ? m - 1 : d;
        end else if (en) begin
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
            nq = up ? ((q + 1 > m - 1) ? m - 1 : q + 1) : ((q - 1 < 0) ? 0 : q - 1);
`else
            nq   = up ? (q + 1) % m : (q - 1 + m) % m;
            novf = up ? (q + 1 == m) : (q == 0);
`endif
        end
    endfunction

    task automatic drive_a(input bit en, input bit up, input bit load, input logic [3:0] d);
        @(negedge clk);
        en_a = en; up_a = up; load_a = load; d_a = d;
        #1;
    endtask

    task automatic drive_b(input bit en, input bit up, input bit load, input logic [3:0] d);
        @(negedge clk);
        en_b = en; up_b = up; load_b = load; d_b = d;
        #1;
    endtask

    task automatic advance_a();
        int nq; bit nov;
        @(posedge clk);
        model_step(10, mq_a, en_a, up_a, load_a, int'(d_a), nq, nov);
        mq_a = nq; movf_a = nov;
        #1;
    endtask

    task automatic advance_b();
        int nq; bit nov;
        @(posedge clk);
        model_step(16, mq_b, en_b, up_b, load_b, int'(d_b), nq, nov);
        mq_b = nq; movf_b = nov;
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (q_a !== 4'd0 || qbar_a !== 4'hF || ovf_a !== 1'b0) begin
            errors++; $display("FAIL reset_a: q=%h qbar=%h ovf=%b required 0 F 0", q_a, qbar_a, ovf_a);
        end
        checks++;
        if (q_b !== 4'd0 || qbar_b !== 4'hF || ovf_b !== 1'b0) begin
            errors++; $display("FAIL reset_b: q=%h qbar=%h ovf=%b required 0 F 0", q_b, qbar_b, ovf_b);
        end
        @(negedge clk);
        r_n = 1'b1;
    endtask

    task automatic test_main(input string name, input int cycles, input int mode);
        logic [3:0] eq;
        for (int i = 0; i < cycles; i++) begin
            case (mode)
                0: drive_a(1, 1, 0, 0);
                1: drive_a(1, 0, 0, 0);
                2: drive_a(0, $urandom_range(0, 1), 0, 4'($urandom_range(0, 15)));
                default: drive_a($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                                 $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
            endcase
            exp_tc = model_tc(10, mq_a, en_a, up_a, load_a);
            checks++;
            if (tc_a !== exp_tc) begin
                errors++; $display("FAIL %s_tc cyc %0d: tc=%b required %b", name, i, tc_a, exp_tc);
            end
            advance_a();
            eq = 4'(mq_a);
            checks++;
            if (q_a !== eq || qbar_a !== ~eq || ovf_a !== movf_a) begin
                errors++;
                $display("FAIL %s_q cyc %0d: q=%h qbar=%h ovf=%b required %h %h %b",
                         name, i, q_a, qbar_a, ovf_a, eq, ~eq, movf_a);
            end
        end
    endtask

    task automatic test_load();
        logic [3:0] eq;
        drive_a(1, 1, 1, 4'd13);
        advance_a();
        checks++;
        if (q_a !== 4'd9 || ovf_a !== 1'b0 || mq_a != 9) begin
            errors++; $display("FAIL load_clamp: q=%h ovf=%b required 9 0", q_a, ovf_a);
        end
        // At the wrap point with en=1: load must win and suppress tc and ovf
        drive_a(1, 1, 1, 4'd3);
        checks++;
        if (tc_a !== 1'b0) begin
            errors++; $display("FAIL load_tc: tc=%b required 0", tc_a);
        end
        advance_a();
        eq = 4'(mq_a);
        checks++;
        if (q_a !== eq || ovf_a !== 1'b0) begin
            errors++; $display("FAIL load_wins: q=%h ovf=%b required %h 0", q_a, ovf_a, eq);
        end
    endtask

    task automatic test_sat_range();
        logic [3:0] eq;
        drive_b(0, 1, 1, 4'd14);
        advance_b();
        for (int i = 0; i < 4; i++) begin
            drive_b(1, 1, 0, 0);
            exp_tc = model_tc(16, mq_b, en_b, up_b, load_b);
            checks++;
            if (tc_b !== exp_tc) begin
                errors++; $display("FAIL sat_tc cyc %0d: tc=%b required %b", i, tc_b, exp_tc);
            end
            advance_b();
            eq = 4'(mq_b);
            checks++;
            if (q_b !== eq || ovf_b !== movf_b) begin
                errors++; $display("FAIL sat_q cyc %0d: q=%h ovf=%b required %h %b", i, q_b, ovf_b, eq, movf_b);
            end
        end
        drive_b(0, 1, 0, 0);
    endtask

    task automatic test_cascade();
        bit wrap;
        int got;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            cen = 1'b1;
            cup = (i < 60);
            #1;
            @(posedge clk);
            wrap = cup ? (mc == 99) : (mc == 0);
            mc = cup ? (mc + 1) % 100 : (mc + 99) % 100;
            #1;
            got = 10 * int'(c2_q) + int'(c1_q);
            checks++;
            if (got != mc || c2_ovf !== wrap) begin
                errors++; $display("FAIL cascade cyc %0d: count=%0d ovf2=%b required %0d %b", i, got, c2_ovf, mc, wrap);
            end
        end
        @(negedge clk);
        cen = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive_b(0, 1, 1, 4'd7);
        advance_b();
        drive_b(1, 1, 0, 0);
        advance_b();
        advance_b();
        checks++;
        if (q_b !== 4'd9) begin
            errors++; $display("FAIL mid_setup: q=%h required 9", q_b);
        end
        #2;
        r_n = 1'b0;
        #1;
        checks++;
        if (q_b !== 4'd0 || qbar_b !== 4'hF || ovf_b !== 1'b0 || q_a !== 4'd0) begin
            errors++; $display("FAIL mid_reset: q=%h qbar=%h ovf=%b qa=%h required 0 F 0 0", q_b, qbar_b, ovf_b, q_a);
        end
        mq_a = 0; movf_a = 0; mq_b = 0; movf_b = 0; mc = 0;
        @(posedge clk);
        #1;
        checks++;
        if (q_b !== 4'd0) begin
            errors++; $display("FAIL mid_hold: q=%h required 0", q_b);
        end
        @(negedge clk);
        r_n = 1'b1;
        advance_b();
        checks++;
        if (q_b !== 4'd1 || mq_b != 1) begin
            errors++; $display("FAIL mid_restart: q=%h required 1", q_b);
        end
    endtask

    initial begin
        r_n = 1'b0;
        en_a = 0; up_a = 0; load_a = 0; d_a = 0;
        en_b = 0; up_b = 0; load_b = 0; d_b = 0;
        cen = 0; cup = 1;
        #2;
        test_reset();
        test_main("up", 12, 0);
        drive_a(0, 0, 1, 4'd0);
        advance_a();
        test_main("down", 12, 1);
        test_load();
        test_main("hold", 4, 2);
        test_main("rand", 300, 3);
        test_sat_range();
`ifndef UPDOWN_MOD_COUNTER_SAT_EN
        test_cascade();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
